// File: rtl/digit_serial_adder_pkg.sv
// Shared definitions for the digit-serial adder: FSM encoding and parameter sanity check.
package digit_serial_adder_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  function automatic bit cfg_ok(input int width, input int digit);
    return (digit >= 1) && (digit <= width) && ((width % digit) == 0);
  endfunction

endpackage

// File: rtl/digit_rca.sv
// Combinational DIGIT-wide ripple-carry adder built from replicated full-adder cells.
// Also exports the carry into the MSB cell so the caller can derive signed overflow.
module digit_rca #(
  parameter int DIGIT = 2
) (
  input  logic [DIGIT-1:0] a_i,
  input  logic [DIGIT-1:0] b_i,
  input  logic             cin_i,
  output logic [DIGIT-1:0] sum_o,
  output logic             cout_o,
  output logic             cmsb_o
);

  // Each cell owns its own carry nets so the chain is not one self-referencing vector.
  for (genvar i = 0; i < DIGIT; i++) begin : g_fa
    logic ci;
    logic co;
    if (i == 0) begin : g_first
      assign ci = cin_i;
    end else begin : g_next
      assign ci = g_fa[i-1].co;
    end
    assign sum_o[i] = a_i[i] ^ b_i[i] ^ ci;
    assign co       = (a_i[i] & b_i[i]) | (ci & (a_i[i] ^ b_i[i]));
  end

  assign cout_o = g_fa[DIGIT-1].co;
  assign cmsb_o = g_fa[DIGIT-1].ci;

endmodule

// File: rtl/digit_serial_adder.sv
// Multi-cycle adder/subtractor: DIGIT bits per cycle, carry held in a register between digits.
// Operands accepted only in IDLE; result held in DONE until consumed (no skid).
module digit_serial_adder
  import digit_serial_adder_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DIGIT = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int NDIG = WIDTH / DIGIT;
  localparam int CW   = (NDIG > 1) ? $clog2(NDIG) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(NDIG - 1);

  if (!cfg_ok(WIDTH, DIGIT)) begin : g_bad_cfg
    $error("digit_serial_adder: WIDTH must be a positive multiple of DIGIT");
  end

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             carry_q, carry_d;
  logic             cout_q, cout_d;
  logic             ovf_q, ovf_d;
  logic [CW-1:0]    cnt_q, cnt_d;

  logic [DIGIT-1:0] dig_sum;
  logic             dig_cout;
  logic             dig_cmsb;
  logic [WIDTH-1:0] dig_ext;

  digit_rca #(.DIGIT(DIGIT)) u_rca (
    .a_i    (a_q[DIGIT-1:0]),
    .b_i    (b_q[DIGIT-1:0]),
    .cin_i  (carry_q),
    .sum_o  (dig_sum),
    .cout_o (dig_cout),
    .cmsb_o (dig_cmsb)
  );

  // New digit enters at the top; after NDIG shifts the first digit sits at bit 0.
  assign dig_ext = WIDTH'(dig_sum) << (WIDTH - DIGIT);

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    sum_d   = sum_q;
    carry_d = carry_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          a_d     = a;
          b_d     = sub ? ~b : b;
          carry_d = sub ? ~cin : cin;
          cnt_d   = '0;
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        sum_d   = (sum_q >> DIGIT) | dig_ext;
        a_d     = a_q >> DIGIT;
        b_d     = b_q >> DIGIT;
        carry_d = dig_cout;
        if (cnt_q == CNT_LAST) begin
          cout_d  = dig_cout;
          ovf_d   = dig_cmsb ^ dig_cout;
          state_d = ST_DONE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      ST_DONE: begin
        if (out_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sum_q   <= sum_d;
      carry_q <= carry_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
      cnt_q   <= cnt_d;
    end
  end

  assign in_ready  = (state_q == ST_IDLE);
  assign out_valid = (state_q == ST_DONE);
  assign sum       = sum_q;
  assign cout      = cout_q;
  assign ovf       = ovf_q;

endmodule

// File: tb/tb_digit_serial_adder.sv
// Bench for digit_serial_adder: four parameterisations, directed cases and random sweeps against a reference model.
module tb_digit_serial_adder;

  localparam int NI = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // Instance k: 0 = 8/2, 1 = 8/8, 2 = 32/4, 3 = 16/1
  int wid  [NI] = '{8, 8, 32, 16};
  int ndig [NI] = '{4, 1, 8, 16};

  logic        in_valid_v  [NI];
  logic        out_ready_v [NI];
  logic        cin_v       [NI];
  logic        sub_v       [NI];
  logic [31:0] a_v         [NI];
  logic [31:0] b_v         [NI];
  logic        in_ready_w  [NI];
  logic        out_valid_w [NI];
  logic        cout_w      [NI];
  logic        ovf_w       [NI];
  logic [31:0] sum_w       [NI];

  logic [7:0]  sum0;
  logic [7:0]  sum1;
  logic [31:0] sum2;
  logic [15:0] sum3;
  assign sum_w[0] = 32'(sum0);
  assign sum_w[1] = 32'(sum1);
  assign sum_w[2] = sum2;
  assign sum_w[3] = 32'(sum3);

  digit_serial_adder #(.WIDTH(8), .DIGIT(2)) u_d0 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid_v[0]), .in_ready(in_ready_w[0]),
    .a(a_v[0][7:0]), .b(b_v[0][7:0]), .cin(cin_v[0]), .sub(sub_v[0]),
    .out_valid(out_valid_w[0]), .out_ready(out_ready_v[0]),
    .sum(sum0), .cout(cout_w[0]), .ovf(ovf_w[0]));

  digit_serial_adder #(.WIDTH(8), .DIGIT(8)) u_d1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid_v[1]), .in_ready(in_ready_w[1]),
    .a(a_v[1][7:0]), .b(b_v[1][7:0]), .cin(cin_v[1]), .sub(sub_v[1]),
    .out_valid(out_valid_w[1]), .out_ready(out_ready_v[1]),
    .sum(sum1), .cout(cout_w[1]), .ovf(ovf_w[1]));

  digit_serial_adder #(.WIDTH(32), .DIGIT(4)) u_d2 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid_v[2]), .in_ready(in_ready_w[2]),
    .a(a_v[2]), .b(b_v[2]), .cin(cin_v[2]), .sub(sub_v[2]),
    .out_valid(out_valid_w[2]), .out_ready(out_ready_v[2]),
    .sum(sum2), .cout(cout_w[2]), .ovf(ovf_w[2]));

  digit_serial_adder #(.WIDTH(16), .DIGIT(1)) u_d3 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid_v[3]), .in_ready(in_ready_w[3]),
    .a(a_v[3][15:0]), .b(b_v[3][15:0]), .cin(cin_v[3]), .sub(sub_v[3]),
    .out_valid(out_valid_w[3]), .out_ready(out_ready_v[3]),
    .sum(sum3), .cout(cout_w[3]), .ovf(ovf_w[3]));

  typedef struct {
    logic [31:0] sum;
    logic        cout;
    logic        ovf;
  } exp_t;

  exp_t sb[$];
  int checks = 0;
  int failures = 0;

  function automatic exp_t model(input int w, input logic [31:0] a, input logic [31:0] b,
                                 input logic cin, input logic sub);
    logic [63:0] mask, aa, bb, full;
    logic        cc;
    exp_t        e;
    mask   = (64'd1 << w) - 64'd1;
    aa     = {32'd0, a} & mask;
    bb     = sub ? (~{32'd0, b}) & mask : {32'd0, b} & mask;
    cc     = sub ? ~cin : cin;
    full   = aa + bb + 64'(cc);
    e.sum  = 32'(full & mask);
    e.cout = full[w];
    e.ovf  = (aa[w-1] == bb[w-1]) && (e.sum[w-1] != aa[w-1]);
    return e;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input int k, input logic [31:0] a, input logic [31:0] b,
                       input logic cin, input logic sub);
    a_v[k] = a;
    b_v[k] = b;
    cin_v[k] = cin;
    sub_v[k] = sub;
    in_valid_v[k] = 1'b1;
  endtask

  task automatic send(input int k, input logic [31:0] a, input logic [31:0] b,
                      input logic cin, input logic sub);
    int n = 0;
    drive(k, a, b, cin, sub);
    while (!in_ready_w[k] && n < 200) begin
      tick();
      n++;
    end
    chk("in_ready_before_accept", 64'(in_ready_w[k]), 64'd1);
    sb.push_back(model(wid[k], a, b, cin, sub));
    tick();
    in_valid_v[k] = 1'b0;
    chk("busy_after_accept", 64'(in_ready_w[k]), 64'd0);
  endtask

  task automatic wait_valid(input int k, output int n);
    n = 0;
    while (!out_valid_w[k] && n < 200) begin
      tick();
      n++;
    end
    chk("out_valid_wait", 64'(out_valid_w[k]), 64'd1);
  endtask

  task automatic check_result(input int k, input string tag);
    exp_t e;
    if (sb.size() == 0) begin
      checks++;
      failures++;
      $error("FAIL %s_scoreboard observed=empty expected=entry", tag);
    end else begin
      e = sb.pop_front();
      chk({tag, "_sum"}, 64'(sum_w[k]), 64'(e.sum));
      chk({tag, "_cout"}, 64'(cout_w[k]), 64'(e.cout));
      chk({tag, "_ovf"}, 64'(ovf_w[k]), 64'(e.ovf));
    end
  endtask

  task automatic handshake(input int k);
    out_ready_v[k] = 1'b1;
    tick();
    out_ready_v[k] = 1'b0;
    chk("idle_after_consume", 64'(in_ready_w[k]), 64'd1);
    chk("valid_drop_after_consume", 64'(out_valid_w[k]), 64'd0);
  endtask

  task automatic recv(input int k, input bit lat, input string tag);
    int n;
    wait_valid(k, n);
    if (lat) chk({tag, "_latency"}, 64'(n), 64'(ndig[k]));
    check_result(k, tag);
    handshake(k);
  endtask

  // Spec vectors: checked both against literal answers and the scoreboard model.
  task automatic directed(input int k, input logic [31:0] a, input logic [31:0] b,
                          input logic cin, input logic sub, input logic [31:0] xs,
                          input logic xc, input logic xo, input string tag);
    int n;
    send(k, a, b, cin, sub);
    wait_valid(k, n);
    chk({tag, "_latency"}, 64'(n), 64'(ndig[k]));
    chk({tag, "_lit_sum"}, 64'(sum_w[k]), 64'(xs));
    chk({tag, "_lit_cout"}, 64'(cout_w[k]), 64'(xc));
    chk({tag, "_lit_ovf"}, 64'(ovf_w[k]), 64'(xo));
    check_result(k, tag);
    handshake(k);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog observed=timeout expected=completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [31:0] m, ra, rb;
    int n;
    for (int k = 0; k < NI; k++) begin
      in_valid_v[k] = 1'b0;
      out_ready_v[k] = 1'b0;
      cin_v[k] = 1'b0;
      sub_v[k] = 1'b0;
      a_v[k] = '0;
      b_v[k] = '0;
    end

    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    for (int k = 0; k < NI; k++) begin
      chk("reset_in_ready", 64'(in_ready_w[k]), 64'd1);
      chk("reset_out_valid", 64'(out_valid_w[k]), 64'd0);
      chk("reset_sum", 64'(sum_w[k]), 64'd0);
      chk("reset_cout", 64'(cout_w[k]), 64'd0);
      chk("reset_ovf", 64'(ovf_w[k]), 64'd0);
    end

    directed(0, 32'hFF, 32'h01, 1'b0, 1'b0, 32'h00, 1'b1, 1'b0, "add_ff_01");
    directed(0, 32'h7F, 32'h01, 1'b0, 1'b0, 32'h80, 1'b0, 1'b1, "add_7f_01");
    directed(0, 32'h10, 32'h20, 1'b1, 1'b0, 32'h31, 1'b0, 1'b0, "add_10_20_c");
    directed(0, 32'h05, 32'h07, 1'b0, 1'b1, 32'hFE, 1'b0, 1'b0, "sub_05_07");
    directed(0, 32'h80, 32'h01, 1'b0, 1'b1, 32'h7F, 1'b1, 1'b1, "sub_80_01");
    directed(0, 32'h09, 32'h03, 1'b1, 1'b1, 32'h05, 1'b1, 1'b0, "sub_09_03_b");

    // Backpressure: result must hold while new operands wait at the input.
    send(0, 32'h11, 32'h22, 1'b0, 1'b0);
    wait_valid(0, n);
    check_result(0, "bp_first");
    drive(0, 32'h01, 32'h02, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("bp_hold_sum", 64'(sum_w[0]), 64'h33);
      chk("bp_hold_cout", 64'(cout_w[0]), 64'd0);
      chk("bp_hold_ovf", 64'(ovf_w[0]), 64'd0);
      chk("bp_in_ready_low", 64'(in_ready_w[0]), 64'd0);
      chk("bp_valid_high", 64'(out_valid_w[0]), 64'd1);
    end
    sb.push_back(model(8, 32'h01, 32'h02, 1'b0, 1'b0));
    handshake(0);
    tick();
    in_valid_v[0] = 1'b0;
    chk("bp_next_accepted", 64'(in_ready_w[0]), 64'd0);
    recv(0, 1'b1, "bp_second");

    // Reset two RUN edges into an operation: it must be abandoned.
    drive(0, 32'h55, 32'h11, 1'b0, 1'b0);
    tick();
    in_valid_v[0] = 1'b0;
    tick();
    tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    chk("midrun_rst_out_valid", 64'(out_valid_w[0]), 64'd0);
    chk("midrun_rst_sum", 64'(sum_w[0]), 64'd0);
    chk("midrun_rst_cout", 64'(cout_w[0]), 64'd0);
    chk("midrun_rst_in_ready", 64'(in_ready_w[0]), 64'd1);
    for (int i = 0; i < 6; i++) begin
      tick();
      chk("midrun_rst_no_valid", 64'(out_valid_w[0]), 64'd0);
    end
    directed(0, 32'h3C, 32'h0F, 1'b0, 1'b0, 32'h4B, 1'b0, 1'b0, "post_rst_3c_0f");

    for (int k = 1; k < NI; k++) begin
      m = 32'((64'd1 << wid[k]) - 64'd1);
      for (int i = 0; i < 1000; i++) begin
        ra = $urandom() & m;
        rb = $urandom() & m;
        send(k, ra, rb, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        recv(k, i < 4, "rand");
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/digit_serial_adder.md
Name: digit_serial_adder

Overview:
Parametrised multi-cycle adder/subtractor, the successor to the fixed 8-bit ripple-carry adder. It processes DIGIT bits per clock and holds the carry in a register between digits. This trades latency for area on wide operands. Operands enter and results leave through valid/ready handshakes, so it drops into the datapath between a producing stage and a consuming stage.

Parameters:
- WIDTH, 8, operand and result width in bits; must be an integer multiple of DIGIT.
- DIGIT, 2, bits added per RUN cycle; 1 ≤ DIGIT ≤ WIDTH.
- NDIG (localparam), WIDTH/DIGIT, number of RUN cycles per operation.

Ports:
- clk  in  1  single clock; all state changes on rising edge.
- rst_n  in  1  synchronous, active-low reset.
- in_valid  in  1  operand set presented.
- in_ready  out  1  block can accept operands; high only in IDLE.
- a  in  WIDTH  operand A, unsigned or two's complement.
- b  in  WIDTH  operand B.
- cin  in  1  carry-in (add) / borrow-in (sub).
- sub  in  1  0: add, 1: subtract.
- out_valid  out  1  result available; high only in DONE.
- out_ready  in  1  consumer accepts result.
- sum  out  WIDTH  result.
- cout  out  1  carry-out (add) / not-borrow (sub).
- ovf  out  1  signed overflow.

Behaviour:
- Reset (rst_n=0 at a clock edge): state←IDLE; out_valid=0; sum, cout, ovf = 0; in_ready=1 from the following cycle. All internal registers are cleared.
- FSM states are IDLE, RUN, DONE.
- IDLE:
  - in_ready=1.
  - When in_valid&in_ready at an edge: latch a, and b' = sub ? ~b : b.
  - Carry register ← sub ? ~cin : cin.
  - Clear digit counter; go to RUN.
  - Operand changes at the inputs while not in IDLE are ignored.
- RUN:
  - Each edge adds the low DIGIT bits of the A and B' shift registers plus the carry register.
  - The DIGIT-bit digit sum shifts into the top of the sum register; A and B' shift right by DIGIT.
  - The carry register takes the digit carry-out.
  - Digit counter increments; after NDIG RUN edges, go to DONE.
  - On the final digit, latch cout = digit carry-out and ovf = (carry into MSB) XOR (carry out of MSB).
- Latency: out_valid rises exactly NDIG cycles after the accepting edge; for DIGIT=WIDTH it is 1 cycle.
- DONE:
  - out_valid=1; sum/cout/ovf stable and held until out_valid&out_ready at an edge, then go to IDLE.
  - in_ready is 0 throughout RUN and DONE; there is no result skid.
  - Throughput is one operation per NDIG+2 cycles with out_ready held high.
- Arithmetic:
  - sub=0: {cout,sum} = a + b + cin.
  - sub=1: sum = a − b − cin mod 2^WIDTH, computed as a + ~b + ~cin. cout=1 means no borrow.
- Boundary conditions:
  - out_ready high on DONE entry: handshake completes on the first DONE edge.
  - in_valid asserted during RUN/DONE: not accepted; the producer must hold it.
  - Reset mid-RUN or mid-DONE: operation is abandoned and no out_valid is produced; reset has priority over all handshakes.
  - Counter wrap: the counter never exceeds NDIG−1 and is cleared on accept.

Decomposition:
- Shared package/header: FSM state encoding (IDLE=2'd0, RUN=2'd1, DONE=2'd2) and the WIDTH % DIGIT == 0 elaboration check.
- One sub-module, digit_rca: combinational DIGIT-wide ripple adder built from generate-replicated full-adder cells. It also exports the carry into its MSB for the ovf calculation.
- digit_serial_adder contains the FSM, shift registers, carry register and counter.

Test Plan:
1. WIDTH=8, DIGIT=2, add 0xFF+0x01, cin=0 → sum=0x00, cout=1, ovf=0; out_valid exactly 4 cycles after accept.
2. Add 0x7F+0x01, cin=0 → sum=0x80, cout=0, ovf=1; add 0x10+0x20, cin=1 → sum=0x31, cout=0, ovf=0.
3. sub=1:
   - 0x05−0x07, cin=0 → sum=0xFE, cout=0, ovf=0.
   - 0x80−0x01, cin=0 → sum=0x7F, cout=1, ovf=1.
   - 0x09−0x03, cin=1 → sum=0x05, cout=1.
4. Backpressure: hold out_ready=0 for 3 cycles in DONE while driving in_valid=1 with new operands → sum/cout/ovf unchanged and in_ready=0. On out_ready=1 the result is consumed, the FSM is in IDLE, and the new operands are accepted on the next edge.
5. Assert rst_n=0 for one edge after 2 RUN cycles → out_valid=0, sum=0, in_ready=1 the following cycle. A subsequent 0x3C+0x0F → 0x4B completes correctly.
6. Parameter sweep with 1000 random vectors each vs a reference model (a±b±cin), checking sum, cout and ovf:
   - WIDTH=8/DIGIT=8 (latency 1).
   - WIDTH=32/DIGIT=4 (latency 8).
   - WIDTH=16/DIGIT=1 (latency 16).
